// File: rtl/wb_sram_slave_if.sv
// Wishbone classic bus bundle between a bus master (CPU IF/MEM port via the
// arbiter) and one wb_sram_slave bank. Signal names follow the slave's view.
interface wb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    wb_cyc_i;
  logic                    wb_stb_i;
  logic                    wb_we_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_i;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_i;
  logic                    wb_ack_o;
  logic                    wb_err_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;

  // The master drives the request side and observes the termination side.
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_dat_o
  );

  // The slave observes the request side and drives the termination side.
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_dat_o
  );

endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic slave driving an external asynchronous 32-bit SRAM bank.
// One transfer at a time with fixed timing: reads ack three cycles after the
// request is sampled, writes four cycles after (setup / strobe / hold).
// Every output comes straight from a register; the combinational process
// computes the values for the next cycle and the state register loads them.
// Optional feature macro: WB_SRAM_ERR_EN -- when defined, requests whose upper
// address bits fall outside the BASE_ADDR window get a one-cycle wb_err_o and
// no SRAM access; when undefined, wb_err_o is 0 and all addresses alias.
module wb_sram_slave #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    SRAM_ADDR_WIDTH = 20,
  parameter int                    SRAM_DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h8000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  wb_sram_slave_if.slave               wb,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
  output logic                         sram_data_oe,
  output logic                         sram_ce_n,
  output logic                         sram_oe_n,
  output logic                         sram_we_n,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR1,
    WR2,
    WR3,
    ACK
  } state_t;

  state_t                       r_state;
  logic                         r_ack;
  logic                         r_err;
  logic [DATA_WIDTH-1:0]        r_datO;
  logic [SRAM_ADDR_WIDTH-1:0]   r_addr;
  logic [SRAM_DATA_WIDTH-1:0]   r_dataO;
  logic                         r_dataOe;
  logic                         r_ceN;
  logic                         r_oeN;
  logic                         r_weN;
  logic [SRAM_DATA_WIDTH/8-1:0] r_beN;

  state_t                       w_stateNext;
  logic                         w_ackNext;
  logic                         w_errNext;
  logic [DATA_WIDTH-1:0]        w_datONext;
  logic [SRAM_ADDR_WIDTH-1:0]   w_addrNext;
  logic [SRAM_DATA_WIDTH-1:0]   w_dataONext;
  logic                         w_dataOeNext;
  logic                         w_ceNNext;
  logic                         w_oeNNext;
  logic                         w_weNNext;
  logic [SRAM_DATA_WIDTH/8-1:0] w_beNNext;

  logic                         w_request;
  logic                         w_outOfWindow;
  logic                         w_unused;

  assign w_request = wb.wb_cyc_i & wb.wb_stb_i;

`ifdef WB_SRAM_ERR_EN
  assign w_outOfWindow = (wb.wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2] !=
                          BASE_ADDR[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2]);
`else
  assign w_outOfWindow = 1'b0;
`endif

  // Byte-offset bits (and, without the window check, the upper address bits
  // and the base address) intentionally play no part in the datapath.
  assign w_unused = ^{wb.wb_adr_i, BASE_ADDR};

  // Next-state and next-output decode; defaults describe a quiet bus with
  // all SRAM strobes inactive, so any path not listed below (including an
  // abort on wb_cyc_i low) lands in IDLE with the pad released.
  always_comb begin
    w_stateNext  = IDLE;
    w_ackNext    = 1'b0;
    w_errNext    = 1'b0;
    w_datONext   = r_datO;
    w_addrNext   = r_addr;
    w_dataONext  = r_dataO;
    w_dataOeNext = 1'b0;
    w_ceNNext    = 1'b1;
    w_oeNNext    = 1'b1;
    w_weNNext    = 1'b1;
    w_beNNext    = '1;

    case (r_state)
      IDLE: begin
        if (w_request) begin
          if (w_outOfWindow) begin
            w_stateNext = ACK;
            w_errNext   = 1'b1;
          end else begin
            w_addrNext  = wb.wb_adr_i[SRAM_ADDR_WIDTH+1:2];
            w_dataONext = wb.wb_dat_i;
            w_ceNNext   = 1'b0;
            if (wb.wb_we_i) begin
              w_stateNext  = WR1;
              w_dataOeNext = 1'b1;
              w_beNNext    = ~wb.wb_sel_i;
            end else begin
              w_stateNext = RD1;
              w_oeNNext   = 1'b0;
              w_beNNext   = '0;
            end
          end
        end
      end

      RD1: begin
        if (wb.wb_cyc_i) begin
          w_stateNext = RD2;
          w_ceNNext   = 1'b0;
          w_oeNNext   = 1'b0;
          w_beNNext   = '0;
        end
      end

      RD2: begin
        if (wb.wb_cyc_i) begin
          w_stateNext = ACK;
          w_ackNext   = 1'b1;
          w_datONext  = sram_data_i;
        end
      end

      WR1: begin
        if (wb.wb_cyc_i) begin
          w_stateNext  = WR2;
          w_ceNNext    = 1'b0;
          w_dataOeNext = 1'b1;
          w_weNNext    = 1'b0;
          w_beNNext    = r_beN;
        end
      end

      WR2: begin
        if (wb.wb_cyc_i) begin
          w_stateNext  = WR3;
          w_ceNNext    = 1'b0;
          w_dataOeNext = 1'b1;
          w_beNNext    = r_beN;
        end
      end

      WR3: begin
        if (wb.wb_cyc_i) begin
          w_stateNext = ACK;
          w_ackNext   = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to the idle bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_datO   <= '0;
      r_addr   <= '0;
      r_dataO  <= '0;
      r_dataOe <= 1'b0;
      r_ceN    <= 1'b1;
      r_oeN    <= 1'b1;
      r_weN    <= 1'b1;
      r_beN    <= '1;
    end else begin
      r_state  <= w_stateNext;
      r_ack    <= w_ackNext;
      r_err    <= w_errNext;
      r_datO   <= w_datONext;
      r_addr   <= w_addrNext;
      r_dataO  <= w_dataONext;
      r_dataOe <= w_dataOeNext;
      r_ceN    <= w_ceNNext;
      r_oeN    <= w_oeNNext;
      r_weN    <= w_weNNext;
      r_beN    <= w_beNNext;
    end
  end

  assign wb.wb_ack_o  = r_ack;
  assign wb.wb_err_o  = r_err;
  assign wb.wb_dat_o  = r_datO;
  assign sram_addr    = r_addr;
  assign sram_data_o  = r_dataO;
  assign sram_data_oe = r_dataOe;
  assign sram_ce_n    = r_ceN;
  assign sram_oe_n    = r_oeN;
  assign sram_we_n    = r_weN;
  assign sram_be_n    = r_beN;

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
Wishbone classic slave that answers the CPU's IF and MEM Wishbone masters and drives an external asynchronous 32-bit SRAM. Handles one transfer at a time with fixed cycle timing, byte-lane writes and full-word reads. Sits behind the bus arbiter/mux, one instance per SRAM bank.

Parameters:
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width
SRAM_ADDR_WIDTH, 20, SRAM word-address width
SRAM_DATA_WIDTH, 32, SRAM data width; must equal DATA_WIDTH
BASE_ADDR, 32'h8000_0000, bank base address; used only by WB_SRAM_ERR_EN

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
wb_cyc_i  in  1  bus cycle valid
wb_stb_i  in  1  transfer strobe
wb_ack_o  out  1  transfer done, one-cycle pulse
wb_err_o  out  1  out-of-window error, one-cycle pulse
wb_adr_i  in  ADDR_WIDTH  byte address
wb_dat_i  in  DATA_WIDTH  write data
wb_dat_o  out  DATA_WIDTH  read data, registered
wb_sel_i  in  DATA_WIDTH/8  byte enables
wb_we_i  in  1  1 = write
sram_addr  out  SRAM_ADDR_WIDTH  word address = wb_adr_i[SRAM_ADDR_WIDTH+1:2]
sram_data_i  in  SRAM_DATA_WIDTH  SRAM read data
sram_data_o  out  SRAM_DATA_WIDTH  SRAM write data
sram_data_oe  out  1  1 = drive sram_data_o onto the pad
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  SRAM_DATA_WIDTH/8  byte enables, active low

Behaviour:
- One clock, clk_i. rst_i is synchronous and active-high.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, sram_addr=0, sram_data_o=0, sram_data_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=all 1. State is IDLE.
- All outputs are registered.
- States: IDLE, RD1, RD2, WR1, WR2, WR3, ACK.
- IDLE: when wb_cyc_i&wb_stb_i are sampled high at edge T0:
  - Latch the address into sram_addr.
  - Latch wb_dat_i into sram_data_o.
  - Latch ~wb_sel_i into sram_be_n.
  - Go to WR1 if wb_we_i=1, else RD1.
- Read:
  - RD1 (T1) and RD2 (T2): ce_n=0, oe_n=0, be_n=0.
  - At the end of RD2, sram_data_i is registered into wb_dat_o.
  - ACK (T3): wb_ack_o=1, all SRAM strobes inactive.
  - Read latency: request sampled at T0, ack high during cycle T3.
- Write:
  - WR1: ce_n=0, data_oe=1, we_n=1 (setup).
  - WR2: we_n=0.
  - WR3: we_n=1, data_oe still 1 (hold).
  - ACK (T4): wb_ack_o=1, data_oe=0.
- ACK always returns to IDLE. wb_ack_o is high for exactly one cycle.
- A new request is accepted at the earliest on the edge after the ACK cycle; strobe still high during ACK is not a new request.
- wb_sel_i=0 on a write: full cycle sequence runs, be_n stays all 1, ack still issued.
- Reads ignore wb_sel_i and return the full word.
- wb_dat_o holds its last read value until the next read completes.
- Abort: wb_cyc_i low in any non-IDLE state:
  - Next state IDLE.
  - All strobes deasserted, data_oe=0.
  - No ack.
- Reset mid-transfer: the next cycle is the reset state and no ack is issued.
- wb_adr_i[1:0] is ignored.
- wb_adr_i, wb_dat_i and wb_we_i changes after acceptance are ignored; latched values are used.

Optional Feature:
WB_SRAM_ERR_EN
- Defined: in IDLE, a request with wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2] != BASE_ADDR[same bits] performs no SRAM access (strobes stay inactive). The next cycle is ACK-like with wb_err_o=1 and wb_ack_o=0; wb_dat_o is unchanged.
- Undefined: wb_err_o is tied 0. Upper address bits are ignored, so every address aliases into the SRAM.

Test Plan:
- Reset: assert rst_i 2 cycles mid-write (in WR2) -> next cycle sram_we_n=1, data_oe=0, ce_n=1, no ack, state IDLE.
- Write then read: write 0xDEADBEEF to 0x8000_0010, sel=4'hF -> sram_addr=0x00004, we_n low exactly 1 cycle, ack at T4. Read back -> wb_dat_o=0xDEADBEEF with ack at T3.
- Byte write: write 0x000000AA, sel=4'b0001, to a word holding 0x11223344 -> be_n=4'b1110 during WR1-WR3. Read returns 0x112233AA (SRAM model honours be_n).
- Abort: drop wb_cyc_i during RD1 -> no ack, oe_n=1 next cycle. A following read at 0x8000_0000 completes normally with ack at T3.
- Back-to-back: master holds stb across 3 consecutive reads -> acks spaced exactly 4 cycles apart, no double ack.
- WB_SRAM_ERR_EN: read 0x9000_0000 -> wb_err_o=1 for 1 cycle, wb_ack_o=0, ce_n stays 1. Without the macro -> ack at T3, sram_addr=0x00000.
